// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS-style pipeline front end.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t       NOP_INSTR        = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT  = 4;
    localparam word_t       RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads on advance, clears to a NOP bubble on flush.
module if_id_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  flush,
    input  word_t instr_in,
    input  word_t pc4_in,
    output word_t instr,
    output word_t pc4,
    output logic  valid
);

    // Flush leaves pc4 untouched; only the instruction and valid bit are squashed.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, redirect handling, IF/ID latch and
// delivery/stall counters.
module fetch_unit
    import mips_pkg::*;
#(
    parameter word_t       RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    output word_t pc,
    input  word_t instr_in,
    input  logic  id_ready,
    input  logic  branch_taken,
    input  word_t branch_target,
    input  logic  jump,
    input  word_t jump_target,
    output word_t if_id_instr,
    output word_t if_id_pc4,
    output logic  if_id_valid,
    output logic  misalign_err,
    output word_t fetch_count,
    output word_t stall_count
);

    word_t pc_q, pc_d;
    word_t pc_seq;
    word_t target;
    logic  redirect;
    logic  advance;
    logic  stall_cycle;
    logic  err_q, err_d;
    word_t fetch_cnt_q, fetch_cnt_d;
    word_t stall_cnt_q, stall_cnt_d;

    assign pc_seq      = pc_q + word_t'(PC_STEP);
    assign redirect    = branch_taken | jump;
    // Branch has priority when both redirects arrive together.
    assign target      = branch_taken ? branch_target : jump_target;
    assign advance     = ~redirect & id_ready;
    assign stall_cycle = ~redirect & ~id_ready & if_id_valid;

    always_comb begin
        pc_d        = pc_q;
        err_d       = err_q;
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (redirect) begin
            pc_d = {target[31:2], 2'b00};
            if (target[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end else if (id_ready) begin
            pc_d = pc_seq;
        end

        if (advance && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (stall_cycle && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            err_q       <= 1'b0;
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            err_q       <= err_d;
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (advance),
        .flush    (redirect),
        .instr_in (instr_in),
        .pc4_in   (pc_seq),
        .instr    (if_id_instr),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

    assign pc           = pc_q;
    assign misalign_err = err_q;
    assign fetch_count  = fetch_cnt_q;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, a hand-written
// redirect corner case, and randomized traffic against a behavioural model.
module tb_fetch_unit;
    import mips_pkg::*;

    logic  clk = 1'b0;
    logic  reset, id_ready, branch_taken, jump;
    word_t branch_target, jump_target, instr_in, pc;
    word_t if_id_instr, if_id_pc4, fetch_count, stall_count;
    logic  if_id_valid, misalign_err;

    word_t imem [256];

    always #5 clk = ~clk;

    assign instr_in = imem[pc[9:2]];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .instr_in      (instr_in),
        .id_ready      (id_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .misalign_err  (misalign_err),
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
    );

    typedef struct {
        bit    rst;
        bit    rdy;
        bit    br;
        word_t bt;
        bit    jmp;
        word_t jt;
        word_t e_pc;
        bit    e_valid;
        word_t e_instr;
        word_t e_pc4;
        bit    e_err;
        word_t e_fc;
        word_t e_sc;
    } vec_t;

    vec_t vecs [21];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference state
    word_t m_pc, m_instr, m_pc4, m_fc, m_sc;
    bit    m_valid, m_err;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input word_t e_pc, input bit e_v,
                             input word_t e_i, input word_t e_pc4, input bit e_err,
                             input word_t e_fc, input word_t e_sc);
        check($sformatf("%s pc", tag), pc, e_pc);
        check($sformatf("%s valid", tag), {31'b0, if_id_valid}, {31'b0, e_v});
        check($sformatf("%s instr", tag), if_id_instr, e_i);
        check($sformatf("%s pc4", tag), if_id_pc4, e_pc4);
        check($sformatf("%s err", tag), {31'b0, misalign_err}, {31'b0, e_err});
        check($sformatf("%s fetch_count", tag), fetch_count, e_fc);
        check($sformatf("%s stall_count", tag), stall_count, e_sc);
    endtask

    task automatic drive(input bit r, input bit rdy, input bit br, input word_t bt,
                         input bit j, input word_t jt);
        reset         = r;
        id_ready      = rdy;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One clock of the architectural rules, applied to the model state.
    task automatic model_step(input bit r, input bit rdy, input bit br, input word_t bt,
                              input bit j, input word_t jt);
        word_t t;
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 0; m_err = 0; m_fc = 0; m_sc = 0;
        end else if (br || j) begin
            t = br ? bt : jt;
            if (t % 4 != 0) m_err = 1;
            m_pc    = t - (t % 4);
            m_valid = 0;
            m_instr = 32'h0;
        end else if (rdy) begin
            m_instr = imem[(m_pc / 4) % 256];
            m_pc4   = m_pc + 4;
            m_pc    = m_pc + 4;
            m_valid = 1;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end else if (m_valid) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end
    endtask

    initial begin
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 256; k++) imem[k] = 32'hA000_0000 | word_t'(k);
        imem[0] = 32'h0021_4020;
        imem[1] = 32'h0001_4820;

        //          rst rdy br bt            j  jt             pc            v  instr          pc4           e  fc  sc
        vecs[0]  = '{1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 0, 0};
        vecs[1]  = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0021_4020, 32'h4,       0, 1, 0};
        vecs[2]  = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        1, 32'h0001_4820, 32'h8,       0, 2, 0};
        vecs[3]  = '{0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 32'h0001_4820, 32'h8,       0, 2, 1};
        vecs[4]  = '{0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 32'h0001_4820, 32'h8,       0, 2, 2};
        vecs[5]  = '{0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 32'h0001_4820, 32'h8,       0, 2, 3};
        vecs[6]  = '{0, 0, 1, 32'h40,       0, 32'h0,        32'h40,       0, 32'h0,        32'h8,        0, 2, 3};
        vecs[7]  = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h44,       1, 32'hA000_0010, 32'h44,      0, 3, 3};
        vecs[8]  = '{0, 1, 1, 32'h80,       1, 32'hC0,       32'h80,       0, 32'h0,        32'h44,       0, 3, 3};
        vecs[9]  = '{0, 0, 0, 32'h0,        0, 32'h0,        32'h80,       0, 32'h0,        32'h44,       0, 3, 3};
        vecs[10] = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h84,       1, 32'hA000_0020, 32'h84,      0, 4, 3};
        vecs[11] = '{0, 1, 0, 32'h0,        1, 32'h13,       32'h10,       0, 32'h0,        32'h84,       1, 4, 3};
        vecs[12] = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h14,       1, 32'hA000_0004, 32'h14,      1, 5, 3};
        vecs[13] = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h18,       1, 32'hA000_0005, 32'h18,      1, 6, 3};
        vecs[14] = '{1, 1, 0, 32'h0,        1, 32'h100,      32'h0,        0, 32'h0,        32'h0,        0, 0, 0};
        vecs[15] = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0021_4020, 32'h4,       0, 1, 0};
        vecs[16] = '{0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0021_4020, 32'h4,       0, 1, 1};
        vecs[17] = '{1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 0, 0};
        vecs[18] = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0021_4020, 32'h4,       0, 1, 0};
        vecs[19] = '{0, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,       32'h4,        0, 1, 0};
        vecs[20] = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'hA000_00FF, 32'h0,       0, 2, 0};

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_instr,
                      vecs[i].e_pc4, vecs[i].e_err, vecs[i].e_fc, vecs[i].e_sc);
        end

        // Misaligned branch wins over aligned jump; stalls on an empty IF/ID are not counted.
        drive(1, 1, 0, 32'h0, 0, 32'h0);
        tick();
        drive(0, 1, 0, 32'h0, 0, 32'h0);
        tick();
        tick();
        drive(0, 1, 1, 32'h42, 1, 32'h80);
        tick();
        check("both_redir pc", pc, 32'h40);
        check("both_redir err", {31'b0, misalign_err}, 32'h1);
        check("both_redir valid", {31'b0, if_id_valid}, 32'h0);
        drive(0, 0, 0, 32'h0, 0, 32'h0);
        repeat (4) tick();
        check("empty_stall sc", stall_count, 32'h0);
        check("empty_stall pc", pc, 32'h40);
        drive(0, 1, 0, 32'h0, 0, 32'h0);
        tick();
        check("post_redir instr", if_id_instr, 32'hA000_0010);
        check("post_redir fc", fetch_count, 32'h3);
        check("post_redir err", {31'b0, misalign_err}, 32'h1);

        // Randomized traffic against the model
        for (int k = 0; k < 256; k++) imem[k] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            bit    r, rdy, br, j;
            word_t bt, jt;
            r   = (n == 0) || ($urandom_range(0, 99) < 2);
            rdy = $urandom_range(0, 99) < 70;
            br  = $urandom_range(0, 99) < 10;
            j   = $urandom_range(0, 99) < 10;
            bt  = ($urandom_range(0, 3) == 0) ? word_t'($urandom) : word_t'($urandom_range(0, 1023));
            jt  = ($urandom_range(0, 3) == 0) ? word_t'($urandom) : word_t'($urandom_range(0, 1023));
            drive(r, rdy, br, bt, j, jt);
            model_step(r, rdy, br, bt, j, jt);
            tick();
            check_all($sformatf("rand%0d", n), m_pc, m_valid, m_instr, m_pc4, m_err, m_fc, m_sc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into PC on reset.
REQ-002 Parameter PC_STEP, default 4, byte increment per sequential fetch.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  output  32  current fetch byte address, driven to instruction memory PC input.
REQ-006 instr_in  input  32  instruction word returned combinationally by instruction memory for pc.
REQ-007 id_ready  input  1  decode stage accepts IF/ID contents this cycle.
REQ-008 branch_taken  input  1  redirect request, target on branch_target.
REQ-009 branch_target  input  32  branch destination byte address.
REQ-010 jump  input  1  redirect request, target on jump_target.
REQ-011 jump_target  input  32  jump destination byte address.
REQ-012 if_id_instr  output  32  registered instruction for decode.
REQ-013 if_id_pc4  output  32  registered fetch address + PC_STEP.
REQ-014 if_id_valid  output  1  IF/ID holds a valid instruction.
REQ-015 misalign_err  output  1  sticky flag, a redirect target had nonzero bits [1:0].
REQ-016 fetch_count  output  32  instructions delivered into IF/ID since reset.
REQ-017 stall_count  output  32  cycles with if_id_valid=1 and id_ready=0 since reset.

Function
REQ-018 Fetch latency SHALL be one cycle: instr_in sampled at edge N appears on if_id_instr after edge N.
REQ-019 Advance (no redirect, id_ready=1): if_id_instr<=instr_in, if_id_pc4<=pc+PC_STEP, if_id_valid<=1, pc<=pc+PC_STEP.
REQ-020 Stall (no redirect, id_ready=0): pc, if_id_instr, if_id_pc4, if_id_valid SHALL hold.
REQ-021 Redirect (branch_taken or jump) SHALL override id_ready: pc<=target with bits [1:0] forced to 0, if_id_valid<=0, if_id_instr<=NOP (32'h0).
REQ-022 branch_taken and jump same cycle: branch_target SHALL win.
REQ-023 Redirect target bits [1:0] nonzero: misalign_err<=1, held until reset.
REQ-024 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 without error.
REQ-025 fetch_count SHALL increment on every advance cycle (REQ-019), saturating at 32'hFFFF_FFFF.
REQ-026 stall_count SHALL increment each cycle if_id_valid=1, id_ready=0, no redirect; saturating at 32'hFFFF_FFFF.
REQ-027 pc output SHALL be the PC register directly, no combinational path from any input.

Reset
REQ-028 reset=1 at a clock edge: pc<=RESET_PC, if_id_instr<=0, if_id_pc4<=0, if_id_valid<=0, misalign_err<=0, both counters<=0.
REQ-029 reset SHALL dominate redirect, stall and advance in the same cycle.
REQ-030 Reset asserted mid-stall or mid-redirect SHALL discard in-flight state; first fetch after release is RESET_PC.

Structure
REQ-031 Shared package mips_pkg SHALL hold word_t (32-bit), NOP_INSTR (32'h0), PC_STEP default and RESET_PC default.
REQ-032 IF/ID register (instr, pc4, valid with hold/flush controls) SHALL be sub-module if_id_reg; PC logic, counters and error flag stay in fetch_unit.

Verification
REQ-033 Reset release, id_ready=1, imem[0]=32'h0021_4020, imem[4]=32'h0001_4820 -> cycle1 if_id_instr=32'h0021_4020, if_id_pc4=4; cycle2 if_id_instr=32'h0001_4820, if_id_pc4=8; fetch_count=2.
REQ-034 id_ready=0 for 3 cycles with valid IF/ID -> pc, if_id_* unchanged, stall_count=3, fetch_count unchanged.
REQ-035 branch_taken=1, branch_target=32'h40, id_ready=0 -> next cycle pc=32'h40, if_id_valid=0; following cycle if_id_instr=imem[0x40].
REQ-036 branch_taken=1 (target 32'h80) and jump=1 (target 32'hC0) same cycle -> pc=32'h80.
REQ-037 jump_target=32'h0000_0013 -> pc=32'h10, misalign_err=1 and stays 1 through later fetches until reset.
REQ-038 reset=1 coincident with jump to 32'h100 -> pc=RESET_PC, if_id_valid=0, counters=0, misalign_err=0.
